// File: rtl/core_inst_buffer_if.sv
// ---------------------------------------------------------------------------
// core_inst_buffer_if
//   Bundles the fetch-side (F2 -> buffer) and decode-side (buffer -> decode)
//   signals of the two-wide instruction buffer.
//
//   Fetch side : valid_i[1:0], pc_i[31:0], inst_i[1:0][31:0], attached_i,
//                f2_attached_i  (into buffer), ready_o (out of buffer)
//   Decode side: valid_o[1:0], pc_o[1:0][31:0], inst_o[1:0][31:0],
//                attached_o[1:0], f2_attached_o[1:0] (out of buffer),
//                ready_i[1:0] (into buffer)
//
//   modport slave  : the buffer itself
//   modport master : the surrounding pipeline (fetch + decode)
// ---------------------------------------------------------------------------
interface core_inst_buffer_if #(
  parameter int ATTACHED_INFO_WIDTH    = 32,
  parameter int F2_ATTACHED_INFO_WIDTH = 32
);
  logic [1:0]                                   valid_i;
  logic [31:0]                                  pc_i;
  logic [1:0][31:0]                             inst_i;
  logic [ATTACHED_INFO_WIDTH-1:0]               attached_i;
  logic [F2_ATTACHED_INFO_WIDTH-1:0]            f2_attached_i;
  logic                                         ready_o;
  logic [1:0]                                   valid_o;
  logic [1:0][31:0]                             pc_o;
  logic [1:0][31:0]                             inst_o;
  logic [1:0][ATTACHED_INFO_WIDTH-1:0]          attached_o;
  logic [1:0][F2_ATTACHED_INFO_WIDTH-1:0]       f2_attached_o;
  logic [1:0]                                   ready_i;

  modport slave (
    input  valid_i, pc_i, inst_i, attached_i, f2_attached_i, ready_i,
    output ready_o, valid_o, pc_o, inst_o, attached_o, f2_attached_o
  );

  modport master (
    output valid_i, pc_i, inst_i, attached_i, f2_attached_i, ready_i,
    input  ready_o, valid_o, pc_o, inst_o, attached_o, f2_attached_o
  );
endinterface

// File: rtl/core_inst_buffer.sv
// ---------------------------------------------------------------------------
// core_inst_buffer
//   Two-wide instruction queue between fetch F2 and decode. Accepts up to two
//   instructions per cycle, compacts partially valid fetch pairs into
//   consecutive entries and presents the oldest two entries to decode in
//   program order. Cleared on flush.
//
//   Ports:
//     clk     : clock
//     rst_n   : synchronous active-low reset (pointers only, not contents)
//     flush_i : pipeline flush, empties the buffer on the next edge
//     ibuf    : core_inst_buffer_if.slave (fetch + decode handshakes)
//
//   Optional feature: define IBUF_BYPASS_EN to let incoming instructions
//   reach empty output slots in the same cycle (0-cycle latency).
// ---------------------------------------------------------------------------
module core_inst_buffer #(
  parameter int DEPTH                  = 8,
  parameter int ATTACHED_INFO_WIDTH    = 32,
  parameter int F2_ATTACHED_INFO_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  core_inst_buffer_if.slave  ibuf
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = ATTACHED_INFO_WIDTH;
  localparam int FW = F2_ATTACHED_INFO_WIDTH;
  // Entry word layout: {pc, inst, attached, f2_attached}
  localparam int WW = 64 + AW + FW;

  typedef logic [PW:0] ptr_t;

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count_q;

  logic [WW-1:0] mem_q [DEPTH];

  logic          ready;
  logic          enq_ok;
  logic [1:0]    n_in;
  logic [WW-1:0] lane_word [2];
  logic [WW-1:0] in_word [2];
  logic [1:0]    slot_vld;
  logic          pop0;
  logic          pop1;
  logic [1:0]    n_pop;
  logic [1:0]    n_byp;
  logic [1:0]    head_pop;
  logic [1:0]    n_wr;
  logic [WW-1:0] wr_word0;
  logic [WW-1:0] wr_word1;
  logic [PW-1:0] wr_addr0;
  logic [PW-1:0] wr_addr1;

  // Low PC bits are implied by the lane index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^ibuf.pc_i[2:0];

  assign count_q = tail_q - head_q;

  // Only registered state: a pop this cycle does not open room this cycle.
  assign ready        = count_q <= ptr_t'(DEPTH - 2);
  assign ibuf.ready_o = ready;

  assign enq_ok = (|ibuf.valid_i) && ready && !flush_i;
  assign n_in   = enq_ok ? ({1'b0, ibuf.valid_i[0]} + {1'b0, ibuf.valid_i[1]}) : 2'd0;

  // Per-lane entry words, then compacted so index 0 is the oldest valid lane.
  assign lane_word[0] = {ibuf.pc_i[31:3], 3'b000, ibuf.inst_i[0],
                         ibuf.attached_i, ibuf.f2_attached_i};
  assign lane_word[1] = {ibuf.pc_i[31:3], 3'b100, ibuf.inst_i[1],
                         ibuf.attached_i, ibuf.f2_attached_i};
  assign in_word[0]   = ibuf.valid_i[0] ? lane_word[0] : lane_word[1];
  assign in_word[1]   = lane_word[1];

  // -------------------------------------------------------------------------
  // Output slots: slot gi shows entry head+gi (storage is read
  // asynchronously so an entry is visible the cycle after it is written).
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [PW-1:0] rd_addr;
    logic [WW-1:0] slot_word;
    logic          slot_valid;

    assign rd_addr = head_q[PW-1:0] + PW'(gi);

    always_comb begin
      slot_word  = mem_q[rd_addr];
      slot_valid = count_q > ptr_t'(gi);
`ifdef IBUF_BYPASS_EN
      // Slots beyond the stored entries are filled from the compacted
      // incoming lanes (only possible while fewer than two are stored).
      if (!slot_valid && enq_ok) begin
        if (count_q == ptr_t'(gi)) begin
          slot_word  = in_word[0];
          slot_valid = 1'b1;
        end else if (n_in == 2'd2) begin
          slot_word  = in_word[1];
          slot_valid = 1'b1;
        end
      end
`endif
    end

    assign slot_vld[gi]           = slot_valid;
    assign ibuf.pc_o[gi]          = slot_word[WW-1 -: 32];
    assign ibuf.inst_o[gi]        = slot_word[WW-33 -: 32];
    assign ibuf.attached_o[gi]    = slot_word[AW+FW-1 -: AW];
    assign ibuf.f2_attached_o[gi] = slot_word[FW-1:0];
  end

  assign ibuf.valid_o = slot_vld;

  // Slot 1 only retires together with slot 0 to keep program order.
  assign pop0  = slot_vld[0] & ibuf.ready_i[0];
  assign pop1  = pop0 & slot_vld[1] & ibuf.ready_i[1];
  assign n_pop = {1'b0, pop0} + {1'b0, pop1};

  // Pops beyond the stored entries consume incoming lanes directly.
  always_comb begin
    n_byp = 2'd0;
`ifdef IBUF_BYPASS_EN
    if (count_q < ptr_t'(n_pop)) begin
      n_byp = n_pop - count_q[1:0];
    end
`endif
  end

  assign head_pop = n_pop - n_byp;
  assign n_wr     = n_in - n_byp;
  // When one lane was bypassed only the second compacted lane remains.
  assign wr_word0 = (n_byp == 2'd0) ? in_word[0] : in_word[1];
  assign wr_word1 = in_word[1];
  assign wr_addr0 = tail_q[PW-1:0];
  assign wr_addr1 = tail_q[PW-1:0] + PW'(1);

  always_comb begin
    head_d = head_q + ptr_t'(head_pop);
    tail_d = tail_q + ptr_t'(n_wr);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry contents are not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (n_wr != 2'd0) begin
      mem_q[wr_addr0] <= wr_word0;
    end
    if (n_wr == 2'd2) begin
      mem_q[wr_addr1] <= wr_word1;
    end
  end
endmodule

// File: doc/core_inst_buffer.md
# core_inst_buffer

Two-wide instruction queue between the instruction-fetch F2 stage and decode. It accepts up to two fetched instructions per cycle, compacts partially valid fetch pairs into consecutive entries, and presents the oldest two instructions to decode in program order. It decouples fetch stalls from decode backpressure and is cleared on pipeline flush.

## Interface

Parameters:

- `DEPTH`, default 8: number of entries. Power of two, at least 4.
- `ATTACHED_INFO_WIDTH`, default 32: width of per-instruction F1 attached information.
- `F2_ATTACHED_INFO_WIDTH`, default 32: width of per-instruction F2 attached information.

Ports:

- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: pipeline flush; discards all contents.
- `valid_i` in 2: fetch lane valids. Lane k is the instruction at `{pc_i[31:3], k, 2'b00}`.
- `pc_i` in 32: fetch-pair PC; only bits [31:3] are used.
- `inst_i` in 2x32: lane instructions.
- `attached_i` in ATTACHED_INFO_WIDTH: pair info, copied into each written entry.
- `f2_attached_i` in F2_ATTACHED_INFO_WIDTH: pair info, copied into each written entry.
- `ready_o` out 1: buffer can accept a full pair this cycle.
- `valid_o` out 2: output slot valids; slot 0 holds the oldest instruction.
- `pc_o` out 2x32: slot PCs.
- `inst_o` out 2x32: slot instructions.
- `attached_o` out 2xATTACHED_INFO_WIDTH: per-slot F1 attached info.
- `f2_attached_o` out 2xF2_ATTACHED_INFO_WIDTH: per-slot F2 attached info.
- `ready_i` in 2: decode accept per slot.

## Operation

- **Storage.** Circular array of DEPTH entries. Each entry holds {pc, inst, attached, f2_attached}.
  - Head and tail pointers are log2(DEPTH)+1 bits and wrap naturally.
  - `count_q = tail_q - head_q`, valid range 0..DEPTH.
- **ready_o** is `(DEPTH - count_q) >= 2`, computed from registered state only. It does not depend on dequeue in the same cycle.
- **Enqueue.** Occurs when `|valid_i && ready_o && !flush_i`.
  - Valid lanes are written in lane order starting at the tail.
  - `valid_i = 2'b10` writes one entry, with PC `{pc_i[31:3], 3'b100}`.
  - `2'b01` writes lane 0 only. `2'b11` writes lane 0 then lane 1.
  - Tail advances by popcount(valid_i).
  - When `!ready_o`, inputs are ignored and fetch must hold them.
- **Output.**
  - `valid_o[0] = count_q >= 1`, `valid_o[1] = count_q >= 2`.
  - Slot s shows entry `head_q + s`.
  - Data on invalid slots is don't-care.
- **Dequeue.**
  - `pop0 = valid_o[0] & ready_i[0]`.
  - `pop1 = pop0 & valid_o[1] & ready_i[1]`. Slot 1 never retires without slot 0, so order is preserved.
  - Head advances by pop0 + pop1.
- **Simultaneous enqueue and dequeue** is permitted in the same cycle. The count updates by (enqueued − popped).
- **Flush.** `flush_i` sets head and tail to 0 on the next edge. Same-cycle enqueue and dequeue are discarded.
- **Reset.** `!rst_n` sets head and tail to 0. Reset values: `valid_o = 2'b00`, `ready_o = 1`. Entry contents are not reset.

## Timing

- Without bypass, an instruction enqueued at edge N is visible on `valid_o` in the cycle after edge N.
- Minimum fetch-to-decode latency is 1 cycle.
- Sustained throughput is 2 instructions per cycle when both sides are always ready.
- `ready_o` falls in the cycle after `count_q` reaches DEPTH-1. With DEPTH=8 and count 7, `ready_o = 0` even though one entry is free.
- Full boundary: at count DEPTH there is no enqueue. A pop in that cycle raises `ready_o` in the next cycle.
- Empty boundary: at count 0, `valid_o = 0` and `ready_i` is ignored.
- Pointer wrap-around at DEPTH is transparent to all outputs.

## Configuration

- **`IBUF_BYPASS_EN` defined.** When `count_q < 2` and enqueue conditions hold, output slots not filled from storage are filled combinationally from the compacted incoming lanes in the same cycle.
  - Incoming instructions consumed through bypass are not written.
  - Unconsumed incoming instructions are written at the tail as normal.
  - Fetch-to-decode latency becomes 0 cycles.
  - `ready_o` is still computed from `count_q` only.
- **`IBUF_BYPASS_EN` undefined.** Outputs come from storage only, with 1-cycle latency as specified above.

## Test plan

- After reset, drive `valid_i = 2'b11`, `pc_i = 0x1c000000`, `ready_i = 2'b00` for 1 cycle.
  - Next cycle: `valid_o = 2'b11`, `pc_o = {0x1c000000, 0x1c000004}`.
- Enqueue `valid_i = 2'b10` with `pc_i = 0x1c000008`, then `2'b01` with `pc_i = 0x1c000010`.
  - Required: `valid_o = 2'b11` with `pc_o = {0x1c00000c, 0x1c000010}` (compaction).
- With `ready_i = 2'b00`, enqueue pairs until `ready_o = 0`.
  - Required: DEPTH=8 stops at count 8; a further `valid_i = 2'b11` is not written.
  - Then `ready_i = 2'b11` for 1 cycle: count becomes 6 and `ready_o = 1` in the next cycle.
- With 3 entries stored (A, B, C), drive `ready_i = 2'b10`.
  - Required: nothing popped; A remains at slot 0.
  - Then `ready_i = 2'b01`: only A is popped, and slot 0 shows B.
- With 5 entries stored, assert `flush_i` together with `valid_i = 2'b11` and `ready_i = 2'b11`.
  - Next cycle: `valid_o = 2'b00`, `ready_o = 1`, and no flushed PC appears afterwards.
- Stream 100 random pairs with random `ready_i` across pointer wrap.
  - Required: the output PC sequence equals the input lane sequence, with no loss and no duplication.
  - With `IBUF_BYPASS_EN` defined and empty state, the first pair appears on outputs in the same cycle.
